// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants for the instruction loader and the core's decoders.
// Holds opcodes, funct fields, ALUControl codes, descriptor class codes and loader state.
package rv_isa_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] CLS_R   = 3'b000;
  localparam logic [2:0] CLS_I   = 3'b001;
  localparam logic [2:0] CLS_LW  = 3'b010;
  localparam logic [2:0] CLS_SW  = 3'b011;
  localparam logic [2:0] CLS_BEQ = 3'b100;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LSW = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } loader_state_e;

  // Maps an ALUControl code to funct3; valid is low for undefined codes.
  function automatic logic [3:0] alu_funct3(input logic [2:0] alu);
    logic [3:0] res;
    unique case (alu)
      ALU_ADD, ALU_SUB: res = {1'b1, F3_ADD};
      ALU_AND:          res = {1'b1, F3_AND};
      ALU_OR:           res = {1'b1, F3_OR};
      ALU_SLT:          res = {1'b1, F3_SLT};
      default:          res = 4'b0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: turns one decoded descriptor into an RV32I word.
// Flags descriptors the core's decoder could not round-trip as illegal.
module instr_field_packer
  import rv_isa_pkg::*;
(
  input  logic [2:0]  cls_i,
  input  logic [2:0]  alu_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [12:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic [3:0] f3_info;
  logic       alu_ok;
  logic [2:0] f3;

  assign f3_info = alu_funct3(alu_i);
  assign alu_ok  = f3_info[3];
  assign f3      = f3_info[2:0];

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (cls_i)
      CLS_R: begin
        if (!alu_ok) begin
          illegal_o = 1'b1;
        end else begin
          word_o = {(alu_i == ALU_SUB) ? F7_SUB : F7_BASE, rs2_i, rs1_i, f3, rd_i, OP_R};
        end
      end
      CLS_I: begin
        // No subi in RV32I; negative immediates cover that case.
        if (!alu_ok || alu_i == ALU_SUB) begin
          illegal_o = 1'b1;
        end else begin
          word_o = {imm_i[11:0], rs1_i, f3, rd_i, OP_I};
        end
      end
      CLS_LW: word_o = {imm_i[11:0], rs1_i, F3_LSW, rd_i, OP_LW};
      CLS_SW: word_o = {imm_i[11:5], rs2_i, rs1_i, F3_LSW, imm_i[4:0], OP_SW};
      CLS_BEQ: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ, imm_i[4:1], imm_i[11], OP_BEQ};
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts descriptor beats, encodes them and writes consecutive words
// to instruction memory one cycle after acceptance.
module instr_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [AW-1:0]              base_addr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_cls,
  input  logic [2:0]                 in_alu,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [12:0]                in_imm,
  input  logic                       in_last,
  output logic                       imem_we,
  output logic [AW-1:0]              imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  loader_state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          last_seen_q, last_seen_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic [31:0]   pk_word;
  logic          pk_illegal;
  logic          full;
  logic          accept;

  instr_field_packer u_packer (
    .cls_i     (in_cls),
    .alu_i     (in_alu),
    .rd_i      (in_rd),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .imm_i     (in_imm),
    .word_o    (pk_word),
    .illegal_o (pk_illegal)
  );

  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = (state_q == StLoad) & ~last_seen_q & ~full;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_d       = err_q;
    last_seen_d = last_seen_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StLoad;
          addr_d      = base_addr & ~AW'(3);
          count_d     = '0;
          err_d       = 1'b0;
          last_seen_d = 1'b0;
        end
      end
      StLoad: begin
        // The last beat's write lands this cycle, so DONE follows it.
        if (last_seen_q) state_d = StDone;
        if (full) err_d = 1'b1;
        if (accept) begin
          if (in_last) last_seen_d = 1'b1;
          if (pk_illegal) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = pk_word;
            addr_d  = addr_q + AW'(4);
            count_d = count_q + CW'(1);
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      last_seen_q <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      last_seen_q <= last_seen_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign count      = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a DEPTH=64 instance for encoding/session
// checks and a DEPTH=2 instance for overflow and mid-session reset.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [31:0] base_addr;
  logic        in_valid;
  logic [2:0]  in_cls, in_alu;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [12:0] in_imm;
  logic        in_last;

  logic        in_ready, imem_we, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [6:0]  count;

  logic        in_ready2, imem_we2, busy2, done2, err2;
  logic [31:0] imem_addr2, imem_wdata2;
  logic [1:0]  count2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.DEPTH(64), .AW(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_cls(in_cls), .in_alu(in_alu),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .count(count), .err(err)
  );

  instr_encoder_loader #(.DEPTH(2), .AW(32)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready2), .in_cls(in_cls), .in_alu(in_alu),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .busy(busy2), .done(done2), .count(count2), .err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [2:0] cls, input logic [2:0] alu, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                      input logic last);
    in_valid = 1'b1;
    in_cls   = cls;
    in_alu   = alu;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    in_last  = last;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic session(input logic [31:0] base);
    tick();
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
  endtask

  task automatic exp_write(input string tag, input logic [31:0] a, input logic [31:0] w);
    chk({tag, "_we"}, {31'd0, imem_we}, 32'd1);
    chk({tag, "_addr"}, imem_addr, a);
    chk({tag, "_wdata"}, imem_wdata, w);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; start2 = 1'b0; base_addr = '0;
    in_valid = 1'b0; in_cls = '0; in_alu = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_last = 1'b0;
    #2;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_count", {25'd0, count}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    tick();
    rst = 1'b1;

    // add x3,x1,x2
    session(32'h0);
    chk("add_busy", {31'd0, busy}, 32'd1);
    chk("add_ready", {31'd0, in_ready}, 32'd1);
    beat(3'b000, 3'b000, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    exp_write("add", 32'h0, 32'h002081B3);
    chk("add_count", {25'd0, count}, 32'd1);
    chk("add_ready_after_last", {31'd0, in_ready}, 32'd0);
    tick();
    chk("add_done", {31'd0, done}, 32'd1);
    chk("add_we_off", {31'd0, imem_we}, 32'd0);
    tick();
    chk("add_idle_busy", {31'd0, busy}, 32'd0);
    chk("add_idle_done", {31'd0, done}, 32'd0);

    // sub then slt back-to-back; base low bits are dropped
    session(32'h103);
    beat(3'b000, 3'b001, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
    tick();
    exp_write("sub", 32'h100, 32'h402081B3);
    beat(3'b000, 3'b101, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    exp_write("slt", 32'h104, 32'h0020A1B3);
    chk("slt_count", {25'd0, count}, 32'd2);
    tick();
    chk("slt_done", {31'd0, done}, 32'd1);

    // lw x5,8(x6) ; sw x5,-4(x6)
    session(32'h40);
    beat(3'b010, 3'b000, 5'd5, 5'd6, 5'd0, 13'd8, 1'b0);
    tick();
    exp_write("lw", 32'h40, 32'h00832283);
    beat(3'b011, 3'b000, 5'd0, 5'd6, 5'd5, 13'h1FFC, 1'b1);
    tick();
    in_valid = 1'b0;
    exp_write("sw", 32'h44, 32'hFE532E23);
    tick();
    chk("sw_done", {31'd0, done}, 32'd1);

    // beq x1,x2,-8
    session(32'h80);
    beat(3'b100, 3'b000, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b1);
    tick();
    in_valid = 1'b0;
    exp_write("beq", 32'h80, 32'hFE208CE3);
    tick();
    chk("beq_done", {31'd0, done}, 32'd1);

    // illegal I-ALU sub then addi x1,x0,5
    session(32'h200);
    beat(3'b001, 3'b001, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0);
    tick();
    chk("isub_we", {31'd0, imem_we}, 32'd0);
    chk("isub_err", {31'd0, err}, 32'd1);
    chk("isub_count", {25'd0, count}, 32'd0);
    beat(3'b001, 3'b000, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1);
    tick();
    in_valid = 1'b0;
    exp_write("addi", 32'h200, 32'h00500093);
    chk("addi_count", {25'd0, count}, 32'd1);
    tick();
    chk("addi_done", {31'd0, done}, 32'd1);
    tick();
    chk("err_sticky_idle", {31'd0, err}, 32'd1);

    // start clears err; or x4,x1,x2 then an illegal-class last beat
    session(32'h0);
    chk("start_clears_err", {31'd0, err}, 32'd0);
    beat(3'b000, 3'b011, 5'd4, 5'd1, 5'd2, 13'd0, 1'b0);
    tick();
    exp_write("or", 32'h0, 32'h0020E233);
    beat(3'b101, 3'b000, 5'd4, 5'd1, 5'd2, 13'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("badcls_we", {31'd0, imem_we}, 32'd0);
    chk("badcls_err", {31'd0, err}, 32'd1);
    chk("badcls_count", {25'd0, count}, 32'd1);
    tick();
    chk("badcls_done", {31'd0, done}, 32'd1);

    // DEPTH=2 overflow
    tick();
    start2    = 1'b1;
    base_addr = 32'h1000;
    tick();
    start2 = 1'b0;
    beat(3'b000, 3'b000, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
    tick();
    chk("ov_w0_we", {31'd0, imem_we2}, 32'd1);
    chk("ov_w0_addr", imem_addr2, 32'h1000);
    chk("ov_w0_wdata", imem_wdata2, 32'h002081B3);
    beat(3'b000, 3'b010, 5'd4, 5'd1, 5'd2, 13'd0, 1'b0);
    tick();
    chk("ov_w1_addr", imem_addr2, 32'h1004);
    chk("ov_w1_wdata", imem_wdata2, 32'h0020F233);
    chk("ov_count", {30'd0, count2}, 32'd2);
    chk("ov_ready_low", {31'd0, in_ready2}, 32'd0);
    beat(3'b001, 3'b000, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1);
    tick();
    chk("ov_err", {31'd0, err2}, 32'd1);
    chk("ov_no_write", {31'd0, imem_we2}, 32'd0);
    tick();
    chk("ov_stuck_busy", {31'd0, busy2}, 32'd1);
    chk("ov_no_done", {31'd0, done2}, 32'd0);
    chk("ov_u1_idle", {31'd0, busy}, 32'd0);

    // asynchronous reset mid-session
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_busy", {31'd0, busy2}, 32'd0);
    chk("mrst_err", {31'd0, err2}, 32'd0);
    chk("mrst_count", {30'd0, count2}, 32'd0);
    chk("mrst_addr", imem_addr2, 32'd0);
    chk("mrst_wdata", imem_wdata2, 32'd0);
    chk("mrst_ready", {31'd0, in_ready2}, 32'd0);
    chk("mrst_u1_addr", imem_addr, 32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
